// File: rtl/lsu_port.sv
// Single-outstanding load/store port: checks alignment, holds a size-encoded request
// until grant or timeout, then pulses done for one cycle with the extended load result.
module lsu_port #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_hb_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             misalign_q, misalign_d;
  logic             err_q, err_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       hb_q, hb_d;
  logic [31:0]      wdata_q, wdata_d;

  logic [1:0]       acc_hb;
  logic             acc_aligned;
  logic [31:0]      acc_wdata;
  logic [31:0]      load_ext;

  // Size decode of the incoming access; unlisted funct3 codes fall into the word case.
  always_comb begin
    acc_hb      = 2'b10;
    acc_aligned = (lsu_addr_i[1:0] == 2'b00);
    acc_wdata   = lsu_wdata_i;
    unique case (lsu_funct3_i[1:0])
      2'b00: begin
        acc_hb      = 2'b00;
        acc_aligned = 1'b1;
        acc_wdata   = {24'h0, lsu_wdata_i[7:0]};
      end
      2'b01: begin
        acc_hb      = 2'b01;
        acc_aligned = ~lsu_addr_i[0];
        acc_wdata   = {16'h0, lsu_wdata_i[15:0]};
      end
      default: ;
    endcase
  end

  // funct3[2] selects zero-extension for the sub-word loads.
  always_comb begin
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & mem_rdata_i[7]}}, mem_rdata_i[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    funct3_d   = funct3_q;
    we_d       = we_q;
    addr_d     = addr_q;
    hb_d       = hb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lsu_valid_i) begin
          if (acc_aligned) begin
            state_d  = REQ;
            cnt_d    = '0;
            funct3_d = lsu_funct3_i;
            we_d     = lsu_we_i;
            addr_d   = lsu_addr_i;
            hb_d     = acc_hb;
            wdata_d  = acc_wdata;
          end else begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
            rdata_d    = '0;
          end
        end
      end
      REQ: begin
        // A grant on the last counted cycle still completes normally.
        if (mem_gnt_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'h0 : load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    req_d  = (state_d == REQ);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      funct3_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      hb_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      hb_q       <= hb_d;
      wdata_q    <= wdata_d;
    end
  end

  assign lsu_busy_o     = busy_q;
  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = misalign_q;
  assign lsu_err_o      = err_q;
  assign mem_req_o      = req_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_hb_o       = hb_q;
  assign mem_wdata_o    = wdata_q;

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles the block waits in REQ for grant before aborting; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 lsu_valid_i  input  1  core starts an access; sampled only in IDLE.
REQ-005 lsu_we_i  input  1  1 = store, 0 = load.
REQ-006 lsu_funct3_i  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes are treated as word.
REQ-007 lsu_addr_i  input  32  byte address.
REQ-008 lsu_wdata_i  input  32  store data, right-justified.
REQ-009 lsu_busy_o  output  1  high in REQ and DONE.
REQ-010 lsu_done_o  output  1  one-cycle completion pulse.
REQ-011 lsu_rdata_o  output  32  load result, extended; valid when lsu_done_o=1.
REQ-012 lsu_misalign_o  output  1  qualifies lsu_done_o: access rejected as misaligned.
REQ-013 lsu_err_o  output  1  qualifies lsu_done_o: grant timeout.
REQ-014 mem_req_o  output  1  request to memory responder.
REQ-015 mem_gnt_i  input  1  responder grant; read data valid in the same cycle.
REQ-016 mem_we_o, mem_addr_o[31:0], mem_hb_o[1:0], mem_wdata_o[31:0]  outputs  write enable, byte address, size (00 byte, 01 half, 10 word), right-justified store data.
REQ-017 mem_rdata_i  input  32  right-justified, zero-extended read data from responder.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and DONE.
REQ-019 In IDLE with lsu_valid_i=1 and an aligned access, the block SHALL latch we, funct3, addr and wdata, clear the wait counter, and enter REQ on the next edge.
REQ-020 Alignment SHALL be: half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-021 In IDLE with lsu_valid_i=1 and a misaligned access, the block SHALL go directly to DONE with lsu_misalign_o=1 and SHALL NOT assert mem_req_o.
REQ-022 In REQ, mem_req_o SHALL be 1 and all mem_* outputs SHALL be driven from latched values, constant for the entire duration of REQ.
REQ-023 mem_hb_o SHALL be 00 for funct3[1:0]=00, 01 for funct3[1:0]=01, and 10 otherwise.
REQ-024 mem_wdata_o SHALL be the latched wdata masked to size: [7:0] for byte, [15:0] for half, and upper bits zero.
REQ-025 In REQ with mem_gnt_i=1, the block SHALL enter DONE.
REQ-026 On a load grant, the block SHALL register lsu_rdata_o: LB/LH sign-extend from bit 7/15 of mem_rdata_i, LBU/LHU zero-extend, and word passes through unchanged.
REQ-027 On a store grant, lsu_rdata_o SHALL be 0.
REQ-028 In REQ, the wait counter SHALL increment each cycle without grant; when it equals TIMEOUT-1 and mem_gnt_i=0, the block SHALL enter DONE with lsu_err_o=1.
REQ-029 A grant arriving in the same cycle the counter reaches TIMEOUT-1 SHALL win: normal completion, lsu_err_o=0.
REQ-030 mem_req_o SHALL drop in the cycle after the grant; a grant observed one cycle after entering REQ gives a total latency of 3 cycles from valid to done.
REQ-031 DONE SHALL last exactly one cycle: lsu_done_o=1 there, then return to IDLE.
REQ-032 lsu_misalign_o and lsu_err_o SHALL be 0 outside DONE.
REQ-033 lsu_valid_i SHALL be ignored while lsu_busy_o=1, and a new access SHALL be accepted in the IDLE cycle after DONE.
REQ-034 mem_gnt_i SHALL be ignored outside REQ.

Reset
REQ-035 rst_ni=0 SHALL immediately force state IDLE, counter 0, and all outputs 0, including mem_req_o mid-transaction.
REQ-036 After rst_ni deasserts, no access SHALL be in flight and the first edge with lsu_valid_i=1 starts a fresh access.

Verification
REQ-037 LB at 0x0000_0003, mem_rdata_i=0x0000_0080, grant after 1 cycle in REQ -> mem_hb_o=00, mem_addr_o=0x3, lsu_rdata_o=0xFFFF_FF80, done 3 cycles after valid.
REQ-038 LHU at 0x2, mem_rdata_i=0x0000_8001 -> lsu_rdata_o=0x0000_8001; same access as LH -> 0xFFFF_8001.
REQ-039 SW at 0x1 -> lsu_done_o and lsu_misalign_o pulse in the next cycle, mem_req_o never asserted.
REQ-040 SB at 0x10, wdata=0xDEAD_BEEF, grant held low -> mem_wdata_o=0x0000_00EF for TIMEOUT cycles, then done with lsu_err_o=1; a grant at the final cycle instead gives err=0.
REQ-041 rst_ni pulsed low during REQ -> mem_req_o=0 asynchronously, lsu_busy_o=0, and a following LW at 0x4 completes normally.
REQ-042 lsu_valid_i held high continuously with a grant every REQ cycle -> back-to-back accesses, one done pulse every 3 cycles, no done while mem_req_o is high.
